fsm_rr_scheduler: RTL and testbench
===================================

Name: fsm_rr_scheduler

Overview:
Round-robin scheduler that shares one step-counting sequence engine between NUM_REQ requesters. It grants the engine to one requester at a time and routes that requester's `in` beats into the engine. It releases the grant on completion (STEPS beats counted), timeout, or request withdrawal. It sits between independent sequencing clients and a single shared FSM resource.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
STEPS, 3, beats needed for completion (1..255)
TIMEOUT, 16, max cycles between beats while granted before abort (2..65535)

Ports:
clk  input  1  clock; all logic on rising edge
sync_rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request level, held high until served
in_vec  input  NUM_REQ  per-requester beat; only the owner's bit is observed
grant  output  NUM_REQ  registered one-hot grant (all zero when idle)
busy  output  1  high in RUN state
done_pulse  output  1  one-cycle pulse: owner completed STEPS beats
abort_pulse  output  1  one-cycle pulse: timeout or req withdrawn
done_id  output  $clog2(NUM_REQ)  requester id for done_pulse/abort_pulse; held until next event

Behaviour:
- Reset is synchronous and active-high on sync_rst, clock clk.
- Reset values: state=IDLE; grant=0; busy=0; done_pulse=0; abort_pulse=0; done_id=0; rr pointer=0; beat count=0; timer=0.
- States: IDLE, RUN, REL.
- IDLE:
  - If any req bit is set, select the first set bit scanning from the rr pointer upward, with wrap.
  - Next cycle: RUN, grant=onehot(sel), owner=sel, count=0, timer=0.
  - Request-to-grant latency: 1 cycle.
- RUN, per cycle, in priority order:
  1. req[owner]=0 -> REL; abort_pulse=1 next cycle. A beat in the same cycle is ignored.
  2. in_vec[owner]=1:
     - count++, timer=0.
     - If count+1==STEPS -> REL; done_pulse=1 next cycle.
  3. Otherwise timer++. If timer+1==TIMEOUT -> REL; abort_pulse=1 next cycle.
- REL (1 cycle):
  - grant=0, busy=0, the selected pulse is high, done_id=owner.
  - rr pointer = owner+1, modulo NUM_REQ.
  - Next state IDLE.
- Minimum gap between a final beat and the next grant: REL cycle + IDLE cycle, so the next grant is 3 cycles after the final-beat cycle.
- The engine counts non-consecutive beats (holds on in=0), matching the shared FSM's hold behaviour. Count width is $clog2(STEPS+1).
- Non-owner in_vec bits are ignored at all times. Beats in IDLE or REL are dropped.
- done_pulse and abort_pulse are never high together. grant is never multi-hot.
- sync_rst in any state returns to the reset values on the next edge; an in-flight sequence is lost with no pulse.
- STEPS=1: the first owner beat completes the sequence.

Decomposition:
- Package fsm_sched_pkg:
  - state_t enum {IDLE, RUN, REL}
  - function rr_pick(req, ptr) returning the index and a valid flag
- Sub-module fsm_step_engine:
  - Inputs: clk, sync_rst, clear, beat.
  - Holds the beat counter and inactivity timer.
  - Outputs: last_beat (count+1==STEPS and beat) and timeout (timer+1==TIMEOUT and !beat).
  - Scheduler instantiates one and drives clear on entry to RUN.

Test Plan:
- Reset: sync_rst=1 for 2 cycles with req=4'b1111 -> grant=0, busy=0, no pulses. Release -> grant=4'b0001 one cycle later.
- Completion, defaults: req[2] only; 3 beats on in_vec[2] with gaps of 0,2,5 idle cycles -> done_pulse one cycle after the 3rd beat, done_id=2, grant=0 that cycle. No pulse after only 2 beats.
- Round-robin fairness: req=4'b1111 held; owners complete in turn -> grant sequence 0,1,2,3,0, with a 2-cycle gap (REL + IDLE) between grants.
- Timeout, TIMEOUT=16: grant to 1, one beat, then none -> abort_pulse on the cycle after the 16th beat-free cycle, done_id=1, then rr pointer=2.
- Withdrawal and foreign beats:
  - Owner 3 drops req after 1 beat -> abort_pulse, done_id=3.
  - in_vec[0] toggling while 3 is owner leaves the count unaffected.
- Mid-sequence reset: after 2 of 3 beats assert sync_rst -> no done_pulse; with req held, next grant goes to requester 0 (pointer reset).

Source files
------------

// File: rtl/fsm_rr_scheduler_pkg.sv
// Shared types and the round-robin selection helper for the scheduler.
package fsm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam int MAX_REQ = 16;
    localparam int MAX_IW  = 4;
    localparam int JW      = MAX_IW + 1;

    typedef struct packed {
        logic              valid;
        logic [MAX_IW-1:0] idx;
    } pick_t;

    // First set bit of req at or above ptr, wrapping at n requesters.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [MAX_IW-1:0]  ptr,
                                      input int                 n);
        pick_t          pick;
        logic [JW-1:0]  j;
        pick.valid = 1'b0;
        pick.idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = {1'b0, ptr} + JW'(i);
            j = (j >= JW'(n)) ? (j - JW'(n)) : j;
            if ((i < n) && !pick.valid && req[j[MAX_IW-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = j[MAX_IW-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fsm_rr_scheduler_step_engine.sv
// Shared sequence engine: counts owner beats and beat-free cycles.
module fsm_step_engine #(
    parameter int STEPS   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic clear,
    input  logic beat,
    output logic last_beat,
    output logic timeout
);

    localparam int CW = $clog2(STEPS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;
    logic [TW-1:0] timer_r;

    // Beat counter holds on idle cycles; timer restarts on every beat.
    always_ff @(posedge clk) begin
        if (sync_rst || clear) begin
            count_r <= '0;
            timer_r <= '0;
        end else if (beat) begin
            count_r <= count_r + CW'(1);
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    assign last_beat = beat && (count_r == CW'(STEPS - 1));
    assign timeout   = !beat && (timer_r == TW'(TIMEOUT - 1));

endmodule

// File: rtl/fsm_rr_scheduler.sv
// Round-robin arbiter granting one shared step engine to one requester at a time.
module fsm_rr_scheduler
    import fsm_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STEPS   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         in_vec,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic                       done_pulse,
    output logic                       abort_pulse,
    output logic [$clog2(NUM_REQ)-1:0] done_id
);

    localparam int IW = $clog2(NUM_REQ);

    state_t             state_r;
    logic [IW-1:0]      owner_r;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      next_ptr_s;
    logic [MAX_REQ-1:0] req_pad_s;
    pick_t              pick_s;
    logic               owner_req_s;
    logic               beat_s;
    logic               clear_s;
    logic               last_beat_s;
    logic               timeout_s;

    // Arbitration pick and owner-routed engine controls.
    always_comb begin
        req_pad_s                = '0;
        req_pad_s[NUM_REQ-1:0]   = req;
        pick_s                   = rr_pick(req_pad_s, MAX_IW'(ptr_r), NUM_REQ);
        owner_req_s              = req[owner_r];
        next_ptr_s               = (owner_r == IW'(NUM_REQ - 1)) ? '0 : (owner_r + IW'(1));
        beat_s                   = 1'b0;
        clear_s                  = 1'b0;
        case (state_r)
            IDLE:    clear_s = pick_s.valid;
            RUN:     beat_s  = owner_req_s && in_vec[owner_r];
            default: begin
                beat_s  = 1'b0;
                clear_s = 1'b0;
            end
        endcase
    end

    fsm_step_engine #(
        .STEPS   (STEPS),
        .TIMEOUT (TIMEOUT)
    ) u_engine (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .clear     (clear_s),
        .beat      (beat_s),
        .last_beat (last_beat_s),
        .timeout   (timeout_s)
    );

    // Scheduler FSM with registered grant, status and event outputs.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_r     <= IDLE;
            owner_r     <= '0;
            ptr_r       <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            done_pulse  <= 1'b0;
            abort_pulse <= 1'b0;
            done_id     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_pulse  <= 1'b0;
                    abort_pulse <= 1'b0;
                    if (pick_s.valid) begin
                        state_r <= RUN;
                        owner_r <= IW'(pick_s.idx);
                        grant   <= NUM_REQ'(1'b1) << IW'(pick_s.idx);
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    // Withdrawal outranks a coincident final beat.
                    if (!owner_req_s || last_beat_s || timeout_s) begin
                        state_r     <= REL;
                        grant       <= '0;
                        busy        <= 1'b0;
                        done_id     <= owner_r;
                        ptr_r       <= next_ptr_s;
                        done_pulse  <= owner_req_s && last_beat_s;
                        abort_pulse <= !(owner_req_s && last_beat_s);
                    end else begin
                        state_r <= RUN;
                    end
                end
                REL: begin
                    state_r     <= IDLE;
                    grant       <= '0;
                    busy        <= 1'b0;
                    done_pulse  <= 1'b0;
                    abort_pulse <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    grant       <= '0;
                    busy        <= 1'b0;
                    done_pulse  <= 1'b0;
                    abort_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_rr_scheduler.sv
// Directed bench for fsm_rr_scheduler (NUM_REQ=4, STEPS=3, TIMEOUT=16).
module tb_fsm_rr_scheduler;

    logic       clk = 1'b0;
    logic       sync_rst;
    logic [3:0] req;
    logic [3:0] in_vec;
    logic [3:0] grant;
    logic       busy;
    logic       done_pulse;
    logic       abort_pulse;
    logic [1:0] done_id;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_v;
    wire  [8:0] obs = {grant, busy, done_pulse, abort_pulse, done_id};

    fsm_rr_scheduler #(.NUM_REQ(4), .STEPS(3), .TIMEOUT(16)) dut (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .req         (req),
        .in_vec      (in_vec),
        .grant       (grant),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .abort_pulse (abort_pulse),
        .done_id     (done_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        req      = 4'b0000;
        in_vec   = 4'b0000;
        step();
        step();
        sync_rst = 1'b0;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1;
        req      = 4'b1111;
        in_vec   = 4'b0000;
        step();
        step();
        exp_v = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, exp_v); end
        sync_rst = 1'b0;
        step();
        exp_v = {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_first_grant got=%b want=%b", obs, exp_v); end
    endtask

    task automatic test_completion();
        do_reset();
        req = 4'b0100;
        step();
        exp_v = {4'b0100, 1'b1, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL cmp_grant got=%b want=%b", obs, exp_v); end
        in_vec = 4'b0100; step();
        in_vec = 4'b0000; step(); step();
        in_vec = 4'b0100; step();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL cmp_two_beats got=%b want=%b", obs, exp_v); end
        in_vec = 4'b0000;
        repeat (5) step();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL cmp_gap_hold got=%b want=%b", obs, exp_v); end
        in_vec = 4'b0100; step();
        exp_v = {4'b0000, 1'b0, 1'b1, 1'b0, 2'd2};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL cmp_done got=%b want=%b", obs, exp_v); end
        in_vec = 4'b0000; req = 4'b0000; step();
        exp_v = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL cmp_id_held got=%b want=%b", obs, exp_v); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id;
        logic [1:0] prev_id;
        logic [3:0] exp_g;
        do_reset();
        req     = 4'b1111;
        prev_id = 2'd0;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            exp_g  = 4'b0001 << exp_id;
            in_vec = 4'b0000;
            step();
            exp_v = {exp_g, 1'b1, 1'b0, 1'b0, prev_id};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, obs, exp_v); end
            in_vec = 4'b1111;
            step(); step(); step();
            exp_v = {4'b0000, 1'b0, 1'b1, 1'b0, exp_id};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rr_done k=%0d got=%b want=%b", k, obs, exp_v); end
            in_vec = 4'b0000;
            step();
            exp_v = {4'b0000, 1'b0, 1'b0, 1'b0, exp_id};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rr_gap k=%0d got=%b want=%b", k, obs, exp_v); end
            prev_id = exp_id;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0010;
        step();
        in_vec = 4'b0010; step();
        in_vec = 4'b0000;
        repeat (15) step();
        exp_v = {4'b0010, 1'b1, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL to_before got=%b want=%b", obs, exp_v); end
        step();
        exp_v = {4'b0000, 1'b0, 1'b0, 1'b1, 2'd1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL to_abort got=%b want=%b", obs, exp_v); end
        req = 4'b1111;
        step();
        step();
        exp_v = {4'b0100, 1'b1, 1'b0, 1'b0, 2'd1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL to_next_ptr got=%b want=%b", obs, exp_v); end
    endtask

    task automatic test_withdraw();
        logic [3:0] foreign [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        do_reset();
        req = 4'b1000;
        step();
        in_vec = 4'b1000; step();
        for (int i = 0; i < 4; i++) begin
            in_vec = foreign[i];
            step();
        end
        exp_v = {4'b1000, 1'b1, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL wd_foreign got=%b want=%b", obs, exp_v); end
        in_vec = 4'b1001; step();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL wd_second_beat got=%b want=%b", obs, exp_v); end
        req = 4'b0000; in_vec = 4'b1000; step();
        exp_v = {4'b0000, 1'b0, 1'b0, 1'b1, 2'd3};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL wd_abort got=%b want=%b", obs, exp_v); end
        in_vec = 4'b0000;
    endtask

    task automatic test_midreset();
        do_reset();
        req = 4'b1111;
        step();
        in_vec = 4'b0001;
        step(); step(); step();
        exp_v = {4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mr_first_done got=%b want=%b", obs, exp_v); end
        in_vec = 4'b0000;
        step(); step();
        exp_v = {4'b0010, 1'b1, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mr_second_grant got=%b want=%b", obs, exp_v); end
        in_vec = 4'b0010;
        step(); step();
        sync_rst = 1'b1;
        step();
        exp_v = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mr_no_pulse got=%b want=%b", obs, exp_v); end
        sync_rst = 1'b0; in_vec = 4'b0000;
        step();
        exp_v = {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mr_ptr_reset got=%b want=%b", obs, exp_v); end
    endtask

    initial begin
        sync_rst = 1'b1;
        req      = 4'b0000;
        in_vec   = 4'b0000;
        test_reset();
        test_completion();
        test_fairness();
        test_timeout();
        test_withdraw();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
